// File: rtl/boot_loader_pkg.sv
// Shared definitions for the VerySimpleCPU boot loader.
// Holds the loader state encoding, the image word size in bytes,
// the default RAM address width and a helper for the image size limit.
package boot_loader_pkg;

  localparam int DEFAULT_SIZE = 14;
  localparam int WORD_BYTES   = 4;

  // Largest image (in words) that fits a RAM with 'size' address bits.
  function automatic logic [31:0] max_words(input int size);
    return 32'd1 << size;
  endfunction

  localparam logic [31:0] MAX_WORDS = max_words(DEFAULT_SIZE);

  // Loader states; a plain vector type keeps the encoding legacy-friendly.
  typedef logic [2:0] state_t;
  localparam state_t HDR_LO = 3'd0;
  localparam state_t HDR_HI = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t WRITE  = 3'd3;
  localparam state_t CSUM   = 3'd4;
  localparam state_t RUN    = 3'd5;
  localparam state_t ERR    = 3'd6;

endpackage

// File: rtl/cpu_boot_loader_le_word_packer.sv
// Little-endian word packer for the boot loader.
// Collects accepted bytes LSB first into a 32-bit word and keeps a running
// XOR of every accepted byte.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - synchronous clear of byte index, word and checksum
//   accept     - byte on 'data' is consumed this cycle
//   data       - incoming byte
//   word       - assembled word
//   csum       - XOR of all bytes accepted since the last clear
//   word_full  - the next accepted byte completes the word
module le_word_packer
  import boot_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [7:0]                data,
  output logic [8*WORD_BYTES-1:0]   word,
  output logic [7:0]                csum,
  output logic                      word_full
);

  logic [1:0] byte_idx;

  // Byte lane insertion, checksum accumulation and lane counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= 2'd0;
      word     <= 32'd0;
      csum     <= 8'd0;
    end else if (accept) begin
      word[{byte_idx, 3'b000} +: 8] <= data;
      csum                          <= csum ^ data;
      byte_idx                      <= byte_idx + 2'd1; // wraps 3 -> 0
    end else begin
      byte_idx <= byte_idx;
      word     <= word;
      csum     <= csum;
    end
  end

  assign word_full = (byte_idx == 2'd3);

endmodule

// File: rtl/cpu_boot_loader.sv
// VerySimpleCPU boot loader.
// Holds the CPU in reset while a program image arrives as a byte stream,
// writes it word by word into RAM from address 0, checks the XOR checksum
// and then hands the RAM port to the CPU and releases its reset.
// Image: count lo, count hi, count x 4 bytes (LSB first), XOR of payload.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready - host byte stream (valid/ready)
//   cpu_wrEn/addr/data       - CPU side of the RAM port (used only in RUN)
//   cpu_rst                  - CPU reset, active-high
//   ram_wrEn/addr/data       - shared single-port RAM write port
//   done                     - image loaded, CPU running
//   error                    - load failed, sticky until rst
module cpu_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic            cpu_wrEn,
  input  logic [SIZE-1:0] cpu_addr,
  input  logic [31:0]     cpu_data,
  output logic            cpu_rst,
  output logic            ram_wrEn,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_data,
  output logic            done,
  output logic            error
);

  localparam logic [31:0] LIMIT = max_words(SIZE);

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     count;
  // One extra bit so a full 2^SIZE image does not wrap the index.
  logic [SIZE:0]   word_idx;
  logic            xfer;
  logic [15:0]     hdr_count;
  logic            last_word;
  logic [31:0]     word_reg;
  logic [7:0]      csum;
  logic            word_full;

  assign xfer      = rx_valid & rx_ready;
  assign hdr_count = {rx_data, count[7:0]};
  assign last_word = (32'(word_idx) == (32'(count) - 32'd1));

  le_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == HDR_LO),
    .accept    (xfer && (state == DATA)),
    .data      (rx_data),
    .word      (word_reg),
    .csum      (csum),
    .word_full (word_full)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: begin
        if (xfer) state_nxt = HDR_HI;
        else      state_nxt = HDR_LO;
      end
      HDR_HI: begin
        if (!xfer)                             state_nxt = HDR_HI;
        else if (hdr_count == 16'd0)           state_nxt = CSUM;
        else if (32'(hdr_count) > LIMIT)       state_nxt = ERR;
        else                                   state_nxt = DATA;
      end
      DATA: begin
        if (xfer && word_full) state_nxt = WRITE;
        else                   state_nxt = DATA;
      end
      WRITE: begin
        if (last_word) state_nxt = CSUM;
        else           state_nxt = DATA;
      end
      CSUM: begin
        if (!xfer)              state_nxt = CSUM;
        else if (rx_data == csum) state_nxt = RUN;
        else                    state_nxt = ERR;
      end
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  // State, header count and word address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR_LO;
      count    <= 16'd0;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && (state == HDR_LO)) count[7:0]  <= rx_data;
      else                           count[7:0]  <= count[7:0];
      if (xfer && (state == HDR_HI)) count[15:8] <= rx_data;
      else                           count[15:8] <= count[15:8];
      if (state == WRITE) word_idx <= word_idx + 1'b1;
      else                word_idx <= word_idx;
    end
  end

  // Output decode; RAM port is a zero-latency pass-through from the CPU in RUN.
  always_comb begin
    rx_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    ram_wrEn = 1'b0;
    ram_addr = word_idx[SIZE-1:0];
    ram_data = word_reg;
    if (rst) begin
      rx_ready = 1'b0;
    end else begin
      case (state)
        HDR_LO, HDR_HI, DATA, CSUM: rx_ready = 1'b1;
        WRITE:   ram_wrEn = 1'b1;
        RUN: begin
          cpu_rst  = 1'b0;
          done     = 1'b1;
          ram_wrEn = cpu_wrEn;
          ram_addr = cpu_addr;
          ram_data = cpu_data;
        end
        ERR:     error = 1'b1;
        default: error = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
Sequences VerySimpleCPU start-up. Holds the CPU in reset, receives a program image as a byte stream over a valid/ready interface, and writes it as 32-bit words into the shared single-port RAM starting at address 0. After a good checksum it hands the RAM port to the CPU and releases CPU reset. Sits between the CPU, the RAM and the host byte source (UART receiver) at top level.

Parameters:
SIZE, 14, RAM word-address width; matches CPU addr_toRAM width; maximum image is 2^SIZE words.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  image byte from host
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte; transfer when rx_valid & rx_ready at posedge clk
cpu_wrEn  input  1  CPU RAM write enable
cpu_addr  input  SIZE  CPU RAM address
cpu_data  input  32  CPU RAM write data
cpu_rst  output  1  reset to CPU, active-high
ram_wrEn  output  1  RAM write enable
ram_addr  output  SIZE  RAM address
ram_data  output  32  RAM write data
done  output  1  image loaded, CPU running
error  output  1  load failed; sticky until rst

Behaviour:
- Reset is synchronous and active-high: state=HDR_LO, word_idx=0, byte_idx=0, count=0, csum=0, word_reg=0. While rst is high: rx_ready=0, ram_wrEn=0, cpu_rst=1, done=0, error=0.
- Image format, little-endian: count[7:0], count[15:8], then count words of 4 bytes each (LSB first), then 1 checksum byte = XOR of all payload bytes (header excluded).
- States:
  - HDR_LO: rx_ready=1. On transfer, count[7:0]=rx_data -> HDR_HI.
  - HDR_HI: rx_ready=1. On transfer, count[15:8]=rx_data. Next state: full count==0 -> CSUM; count>2^SIZE -> ERR; else DATA.
  - DATA: rx_ready=1. On transfer, word_reg[8*byte_idx+:8]=rx_data, csum^=rx_data, byte_idx++. When the 4th byte (byte_idx==3) transfers: byte_idx=0 -> WRITE.
  - WRITE: rx_ready=0, exactly 1 cycle. ram_wrEn=1, ram_addr=word_idx, ram_data=word_reg. Then word_idx++; if word_idx==count-1 (pre-increment) -> CSUM, else DATA.
  - CSUM: rx_ready=1. On transfer: rx_data==csum -> RUN, else -> ERR.
  - RUN: terminal until rst. rx_ready=0, done=1, cpu_rst=0. ram_wrEn/ram_addr/ram_data = cpu_wrEn/cpu_addr/cpu_data, combinational pass-through, zero latency.
  - ERR: terminal until rst. rx_ready=0, error=1, cpu_rst=1.
- Outside RUN: cpu_rst=1, CPU inputs ignored. Outside WRITE and RUN: ram_wrEn=0, ram_addr=word_idx, ram_data=word_reg.
- CPU comes out of reset on the first clk edge after entering RUN, so it starts with PC=0.
- Throughput: 1 byte/cycle while rx_ready is high; 5 cycles minimum per word (4 DATA + 1 WRITE).
- rx_valid while rx_ready=0: byte is not consumed; the host holds it. rx_data is ignored without rx_valid.
- Boundaries:
  - count==2^SIZE is legal; the last write goes to address 2^SIZE-1 and word_idx does not wrap before CSUM.
  - count==0: goes straight to CSUM; expected checksum byte is 0x00.
  - rst mid-load: restarts at HDR_LO; partially written RAM contents are left as-is; CPU stays in reset.
- All outputs are combinational decodes of registered state/data, except the RUN pass-through.

Decomposition:
- Package boot_loader_pkg: state enum (HDR_LO, HDR_HI, DATA, WRITE, CSUM, RUN, ERR), localparam WORD_BYTES=4, localparam MAX_WORDS=2**SIZE.
- One sub-module, le_word_packer: byte_idx counter, word_reg assembly, running XOR csum, with clear/accept inputs and a word_full output.
- Top module holds the FSM, count/word_idx registers and the RAM port mux.

Test Plan:
- Good load: stream 02 00 78 56 34 12 F0 DE BC 9A 00 -> writes (addr 0, 0x12345678) and (addr 1, 0x9ABCDEF0), each as a single-cycle ram_wrEn pulse. Then done=1, cpu_rst=0, and cpu_addr=5 / cpu_wrEn=1 appear on ram_addr / ram_wrEn in the same cycle.
- Bad checksum: same image with final byte 01 -> both words still written; error=1, cpu_rst stays 1, rx_ready=0, cpu_* inputs never reach the RAM port.
- Oversize header: 01 40 (count 0x4001) -> ERR immediately after 2nd byte; no ram_wrEn pulses.
- Backpressure: hold rx_valid=1 continuously with a 1-word image -> rx_ready drops for exactly the WRITE cycle; no byte lost or duplicated; word = 0x12345678.
- Empty image: 00 00 00 -> RUN after the 3rd byte with zero RAM writes. Variant 00 00 FF -> ERR.
- Reset mid-load: assert rst for 1 cycle after 6 bytes of a 2-word image -> state back to HDR_LO, cpu_rst=1. A fresh full image then loads and ends with done=1.
